// File: rtl/round_countdown_timer_pkg.sv
// round_timer_pkg: shared state encoding, default limits and saturation helper for the round timer
package round_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} timer_state_t;
  localparam int DEF_MAX_SECONDS = 99;
  localparam int DEF_WARN_SECONDS = 10;
  function automatic logic [7:0] clamp_seconds(input logic [9:0] v, input logic [7:0] max);
    return (v > {2'b00, max}) ? max : v[7:0];
  endfunction
endpackage

// File: rtl/round_countdown_timer_if.sv
// round_countdown_timer_if: control inputs and status outputs of the round countdown timer
// master drives load/start/pause/add and observes seconds/running/tick/warning/expired; slave is the timer
interface round_countdown_timer_if;
  logic load_in;
  logic [7:0] load_value_in;
  logic start_in;
  logic pause_in;
  logic add_in;
  logic [7:0] add_value_in;
  logic [7:0] seconds_out;
  logic running_out;
  logic tick_out;
  logic warning_out;
  logic expired_out;
  modport master(output load_in, load_value_in, start_in, pause_in, add_in, add_value_in,
                 input seconds_out, running_out, tick_out, warning_out, expired_out);
  modport slave(input load_in, load_value_in, start_in, pause_in, add_in, add_value_in,
                output seconds_out, running_out, tick_out, warning_out, expired_out);
endinterface

// File: rtl/round_countdown_timer_tick_prescaler.sv
// tick_prescaler: divides clk_in by CLK_HZ/TICK_HZ into a combinational one-cycle tick
// ports: clk_in, rst_n_in (async active-low), enable_in (count/hold), clear_in (sync clear), tick_out
module tick_prescaler #(
  parameter int CLK_HZ = 65_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic enable_in,
  input  logic clear_in,
  output logic tick_out
);
  localparam int N = CLK_HZ / TICK_HZ;
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [W-1:0] cnt;
  assign tick_out = enable_in && !clear_in && cnt == LAST;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) cnt <= '0;
    else if (clear_in) cnt <= '0;
    else if (enable_in) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/round_countdown_timer.sv
// round_countdown_timer: saturating seconds countdown with pause, bonus time, warning and expiry flags
// ports: clk_in, rst_n_in (async active-low), bus (slave modport: load/start/pause/add in, status out)
module round_countdown_timer
  import round_timer_pkg::*;
#(
  parameter int CLK_HZ = 65_000_000,
  parameter int TICK_HZ = 1,
  parameter int MAX_SECONDS = DEF_MAX_SECONDS,
  parameter int WARN_SECONDS = DEF_WARN_SECONDS
) (
  input logic clk_in,
  input logic rst_n_in,
  round_countdown_timer_if.slave bus
);
  localparam logic [7:0] MAX = 8'(MAX_SECONDS);
  localparam logic [7:0] WARN = 8'(WARN_SECONDS);
  timer_state_t state, state_nx;
  logic [7:0] sec, sec_nx;
  logic [9:0] sum;
  logic tick, expire, clear;
  assign clear = bus.load_in || (state == IDLE && bus.start_in);
  assign bus.seconds_out = sec;
  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_prescaler (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .enable_in(state == RUNNING),
    .clear_in(clear),
    .tick_out(tick)
  );
  // add and tick combine before saturation so a coincident bonus can rescue the last second
  always_comb begin
    sum = {2'b00, sec} + ((bus.add_in && state != EXPIRED) ? {2'b00, bus.add_value_in} : 10'd0);
    sec_nx = bus.load_in ? clamp_seconds({2'b00, bus.load_value_in}, MAX)
           : (sum < {9'd0, tick}) ? 8'd0 : clamp_seconds(sum - {9'd0, tick}, MAX);
    expire = tick && sec_nx == 8'd0;
    state_nx = bus.load_in ? IDLE
             : state == IDLE ? ((bus.start_in && sec != 8'd0) ? RUNNING : IDLE)
             : state == RUNNING ? (expire ? EXPIRED : bus.pause_in ? PAUSED : RUNNING)
             : state == PAUSED ? (bus.start_in ? RUNNING : PAUSED)
             : EXPIRED;
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state <= IDLE;
      sec <= '0;
      bus.running_out <= 1'b0;
      bus.tick_out <= 1'b0;
      bus.warning_out <= 1'b0;
      bus.expired_out <= 1'b0;
    end else begin
      state <= state_nx;
      sec <= sec_nx;
      bus.running_out <= state_nx == RUNNING;
      bus.tick_out <= tick;
      bus.warning_out <= state_nx == RUNNING && sec_nx != 8'd0 && sec_nx <= WARN;
      bus.expired_out <= expire;
    end
endmodule

// File: tb/tb_round_countdown_timer.sv
// tb_round_countdown_timer: scoreboard bench comparing the timer against a cycle-level reference model
module tb_round_countdown_timer;
  localparam int N = 10;
  localparam int MAXS = 99;
  localparam int WARNS = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];
  int m_secs, m_phase;
  bit m_run, m_paused, m_dead;
  round_countdown_timer_if bus();
  round_countdown_timer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] actual();
    return {bus.seconds_out, bus.running_out, bus.tick_out, bus.warning_out, bus.expired_out};
  endfunction
  task automatic chk(input string nm, input logic [11:0] a, input logic [11:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got sec=%0d run=%0b tick=%0b warn=%0b exp=%0b, want sec=%0d run=%0b tick=%0b warn=%0b exp=%0b",
               nm, $time, a[11:4], a[3], a[2], a[1], a[0], e[11:4], e[3], e[2], e[1], e[0]);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() != 0) chk("outputs", actual(), q.pop_front());
  end
  task automatic drive(input bit ld, input int lv, input bit st, input bit pa, input bit ad, input int av);
    bus.load_in = ld;
    bus.load_value_in = 8'(lv);
    bus.start_in = st;
    bus.pause_in = pa;
    bus.add_in = ad;
    bus.add_value_in = 8'(av);
  endtask
  task automatic cyc(input bit ld, input int lv, input bit st, input bit pa, input bit ad, input int av);
    bit tk, ex;
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    drive(ld, lv, st, pa, ad, av);
    tk = m_run && m_phase == N - 1;
    ex = 1'b0;
    if (ld) begin
      m_secs = lv > MAXS ? MAXS : lv;
      m_phase = 0;
      m_run = 0;
      m_paused = 0;
      m_dead = 0;
      tk = 0;
    end else begin
      if (m_run) m_phase = (m_phase + 1) % N;
      n = m_secs + ((ad && !m_dead) ? av : 0) - (tk ? 1 : 0);
      n = n < 0 ? 0 : (n > MAXS ? MAXS : n);
      ex = tk && n == 0;
      if (m_run) begin
        if (ex) begin m_run = 0; m_dead = 1; end
        else if (pa) begin m_run = 0; m_paused = 1; end
      end else if (m_paused) begin
        if (st) begin m_run = 1; m_paused = 0; end
      end else if (!m_dead && st && m_secs > 0) begin
        m_run = 1;
        m_phase = 0;
      end
      m_secs = n;
    end
    q.push_back({8'(m_secs), m_run, tk, m_run && m_secs > 0 && m_secs <= WARNS, ex});
  endtask
  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_async", actual(), 12'd0);
    m_secs = 0;
    m_phase = 0;
    m_run = 0;
    m_paused = 0;
    m_dead = 0;
    q.push_back(12'd0);
  endtask
  task automatic settle();
    @(posedge clk);
    #2;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(58);
    cyc(0, 0, 0, 0, 1, 10);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 20, 1, 0, 0, 0);
    settle();
    chk("expired_load", {3'b0, bus.seconds_out, bus.running_out}, {3'b0, 8'd20, 1'b0});
    cyc(1, 30, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 1, 0, 0);
    idle(50);
    cyc(0, 0, 1, 0, 0, 0);
    idle(12);
    cyc(1, 250, 0, 0, 0, 0);
    settle();
    chk("load_clamp", {4'b0, bus.seconds_out}, 12'd99);
    cyc(1, 95, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1, 20);
    settle();
    chk("add_saturate", {4'b0, bus.seconds_out}, 12'd99);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(9);
    cyc(0, 0, 0, 0, 1, 3);
    settle();
    chk("tick_add_rescue", {2'b0, bus.seconds_out, bus.running_out, bus.expired_out}, {2'b0, 8'd3, 1'b1, 1'b0});
    idle(5);
    cyc(1, 7, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    do_reset();
    idle(5);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 49) == 0,
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20)),
               $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 0 ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255)));
    end
    settle();
    chk("queue_drained", 12'(q.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
